// File: rtl/alu_cdb.sv
`default_nettype none
// ============================================================================
// Module      : alu_cdb
// Description : Integer execution stage downstream of the reservation station.
//               Computes the RV32I ALU result, the branch/jump decision and the
//               redirect target for one issued op per cycle. Each result is
//               queued in a small in-order FIFO, and the head entry is
//               broadcast on the ALU common data bus.
//
// Ports       : clk, rst (async, active-low), rdy (global enable)
//               in_rs_*         issued op, operands, imm, pc, ROB tag
//               out_rs_full     RS must not issue next cycle
//               in_cdb_grant    head entry consumed this cycle
//               out_cdb_*       head entry {tag, value, jump, target}
//               out_overflow    sticky flag: a push was dropped
//               in_rob_misbranch flush of all queued results
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cdb #(
    parameter int ROB_TAG_W = 4,
    parameter int OP_W      = 6,
    parameter int DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic [OP_W-1:0]      in_rs_op,
    input  logic [31:0]          in_rs_value1,
    input  logic [31:0]          in_rs_value2,
    input  logic [31:0]          in_rs_imm,
    input  logic [31:0]          in_rs_pc,
    input  logic [ROB_TAG_W-1:0] in_rs_rob_tag,
    output logic                 out_rs_full,
    input  logic                 in_cdb_grant,
    output logic [ROB_TAG_W-1:0] out_cdb_tag,
    output logic [31:0]          out_cdb_value,
    output logic                 out_cdb_jump,
    output logic [31:0]          out_cdb_target,
    output logic                 out_overflow,
    input  logic                 in_rob_misbranch
);

    // Inside-opcode encodings. Codes 11..18 are the load/store ops, which are
    // executed elsewhere and therefore fall into the unknown (no-push) class.
    localparam logic [OP_W-1:0] OP_NOP   = OP_W'(0);
    localparam logic [OP_W-1:0] OP_LUI   = OP_W'(1);
    localparam logic [OP_W-1:0] OP_AUIPC = OP_W'(2);
    localparam logic [OP_W-1:0] OP_JAL   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_JALR  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(5);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6);
    localparam logic [OP_W-1:0] OP_BLT   = OP_W'(7);
    localparam logic [OP_W-1:0] OP_BGE   = OP_W'(8);
    localparam logic [OP_W-1:0] OP_BLTU  = OP_W'(9);
    localparam logic [OP_W-1:0] OP_BGEU  = OP_W'(10);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(19);
    localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(20);
    localparam logic [OP_W-1:0] OP_SLTIU = OP_W'(21);
    localparam logic [OP_W-1:0] OP_XORI  = OP_W'(22);
    localparam logic [OP_W-1:0] OP_ORI   = OP_W'(23);
    localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(24);
    localparam logic [OP_W-1:0] OP_SLLI  = OP_W'(25);
    localparam logic [OP_W-1:0] OP_SRLI  = OP_W'(26);
    localparam logic [OP_W-1:0] OP_SRAI  = OP_W'(27);
    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(28);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(29);
    localparam logic [OP_W-1:0] OP_SLL   = OP_W'(30);
    localparam logic [OP_W-1:0] OP_SLT   = OP_W'(31);
    localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(32);
    localparam logic [OP_W-1:0] OP_XOR   = OP_W'(33);
    localparam logic [OP_W-1:0] OP_SRL   = OP_W'(34);
    localparam logic [OP_W-1:0] OP_SRA   = OP_W'(35);
    localparam logic [OP_W-1:0] OP_OR    = OP_W'(36);
    localparam logic [OP_W-1:0] OP_AND   = OP_W'(37);

    localparam int               PTR_W     = $clog2(DEPTH);
    localparam int               CNT_W     = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ALMST = CNT_W'(DEPTH - 1);

    // ------------------------------------------------------------------
    // ALU: next entry computed combinationally from the issue inputs
    // ------------------------------------------------------------------
    logic        entry_valid_d;
    logic [31:0] entry_value_d;
    logic        entry_jump_d;
    logic [31:0] entry_target_d;

    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [31:0] pc_imm;
    logic        lt_s;
    logic        lt_u;
    logic        lt_si;
    logic        lt_ui;

    assign a      = in_rs_value1;
    assign b      = in_rs_value2;
    assign imm    = in_rs_imm;
    assign pc_imm = in_rs_pc + in_rs_imm;
    assign lt_s   = $signed(a) < $signed(b);
    assign lt_u   = a < b;
    assign lt_si  = $signed(a) < $signed(imm);
    assign lt_ui  = a < imm;

    always_comb begin
        entry_valid_d  = 1'b1;
        entry_value_d  = 32'd0;
        entry_jump_d   = 1'b0;
        entry_target_d = 32'd0;
        case (in_rs_op)
            OP_LUI:   entry_value_d = imm;
            OP_AUIPC: entry_value_d = pc_imm;
            OP_JAL: begin
                entry_value_d  = in_rs_pc + 32'd4;
                entry_jump_d   = 1'b1;
                entry_target_d = pc_imm;
            end
            OP_JALR: begin
                entry_value_d  = in_rs_pc + 32'd4;
                entry_jump_d   = 1'b1;
                entry_target_d = (a + imm) & ~32'd1;
            end
            OP_BEQ:  begin entry_jump_d = (a == b); entry_target_d = pc_imm; end
            OP_BNE:  begin entry_jump_d = (a != b); entry_target_d = pc_imm; end
            OP_BLT:  begin entry_jump_d = lt_s;     entry_target_d = pc_imm; end
            OP_BGE:  begin entry_jump_d = !lt_s;    entry_target_d = pc_imm; end
            OP_BLTU: begin entry_jump_d = lt_u;     entry_target_d = pc_imm; end
            OP_BGEU: begin entry_jump_d = !lt_u;    entry_target_d = pc_imm; end
            OP_ADDI:  entry_value_d = a + imm;
            OP_SLTI:  entry_value_d = {31'd0, lt_si};
            OP_SLTIU: entry_value_d = {31'd0, lt_ui};
            OP_XORI:  entry_value_d = a ^ imm;
            OP_ORI:   entry_value_d = a | imm;
            OP_ANDI:  entry_value_d = a & imm;
            OP_SLLI:  entry_value_d = a << imm[4:0];
            OP_SRLI:  entry_value_d = a >> imm[4:0];
            OP_SRAI:  entry_value_d = 32'($signed(a) >>> imm[4:0]);
            OP_ADD:   entry_value_d = a + b;
            OP_SUB:   entry_value_d = a - b;
            OP_SLL:   entry_value_d = a << b[4:0];
            OP_SLT:   entry_value_d = {31'd0, lt_s};
            OP_SLTU:  entry_value_d = {31'd0, lt_u};
            OP_XOR:   entry_value_d = a ^ b;
            OP_SRL:   entry_value_d = a >> b[4:0];
            OP_SRA:   entry_value_d = 32'($signed(a) >>> b[4:0]);
            OP_OR:    entry_value_d = a | b;
            OP_AND:   entry_value_d = a & b;
            // NOP and every op this unit does not execute: nothing to push
            default:  entry_valid_d = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Result FIFO
    // ------------------------------------------------------------------
    logic [ROB_TAG_W-1:0] tag_q    [DEPTH];
    logic [31:0]          value_q  [DEPTH];
    logic                 jump_q   [DEPTH];
    logic [31:0]          target_q [DEPTH];
    logic [PTR_W-1:0]     rptr_q;
    logic [PTR_W-1:0]     wptr_q;
    logic [CNT_W-1:0]     count_q;
    logic                 overflow_q;
    // Last head value/target, shown on the bus while the FIFO is empty
    logic [31:0]          hold_value_q;
    logic [31:0]          hold_target_q;

    logic push_req;
    logic pop_req;
    logic do_write;
    logic empty;

    assign empty    = (count_q == '0);
    assign push_req = rdy && !in_rob_misbranch && entry_valid_d &&
                      (in_rs_op != OP_NOP) && (in_rs_rob_tag != '0);
    assign pop_req  = rdy && !in_rob_misbranch && !empty && in_cdb_grant;
    // A push at full is only accepted when the head frees its slot this cycle
    assign do_write = push_req && ((count_q != CNT_FULL) || pop_req);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i]    <= '0;
                value_q[i]  <= '0;
                jump_q[i]   <= 1'b0;
                target_q[i] <= '0;
            end
            rptr_q        <= '0;
            wptr_q        <= '0;
            count_q       <= '0;
            overflow_q    <= 1'b0;
            hold_value_q  <= '0;
            hold_target_q <= '0;
        end else if (rdy) begin
            if (in_rob_misbranch) begin
                rptr_q  <= '0;
                wptr_q  <= '0;
                count_q <= '0;
            end else begin
                if (do_write) begin
                    tag_q[wptr_q]    <= in_rs_rob_tag;
                    value_q[wptr_q]  <= entry_value_d;
                    jump_q[wptr_q]   <= entry_jump_d;
                    target_q[wptr_q] <= entry_target_d;
                    wptr_q           <= wptr_q + PTR_W'(1);
                end
                if (pop_req) begin
                    rptr_q <= rptr_q + PTR_W'(1);
                end
                case ({do_write, pop_req})
                    2'b10:   count_q <= count_q + CNT_W'(1);
                    2'b01:   count_q <= count_q - CNT_W'(1);
                    default: count_q <= count_q;
                endcase
                if (push_req && !do_write) begin
                    overflow_q <= 1'b1;
                end
            end
            if (!empty) begin
                hold_value_q  <= value_q[rptr_q];
                hold_target_q <= target_q[rptr_q];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_rs_full    = (count_q >= CNT_ALMST);
    assign out_overflow   = overflow_q;
    assign out_cdb_tag    = empty ? '0 : tag_q[rptr_q];
    assign out_cdb_jump   = empty ? 1'b0 : jump_q[rptr_q];
    assign out_cdb_value  = empty ? hold_value_q : value_q[rptr_q];
    assign out_cdb_target = empty ? hold_target_q : target_q[rptr_q];

endmodule
`default_nettype wire

// File: tb/tb_alu_cdb.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_cdb
// Description : Directed self-checking bench for alu_cdb.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_cdb;

    localparam logic [5:0] OP_NOP   = 6'd0;
    localparam logic [5:0] OP_LUI   = 6'd1;
    localparam logic [5:0] OP_AUIPC = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_JALR  = 6'd4;
    localparam logic [5:0] OP_BLT   = 6'd7;
    localparam logic [5:0] OP_BGE   = 6'd8;
    localparam logic [5:0] OP_BLTU  = 6'd9;
    localparam logic [5:0] OP_ADDI  = 6'd19;
    localparam logic [5:0] OP_SRAI  = 6'd27;
    localparam logic [5:0] OP_SUB   = 6'd29;
    localparam logic [5:0] OP_SLT   = 6'd31;
    localparam logic [5:0] OP_SLTU  = 6'd32;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic [5:0]  op;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [3:0]  tag;
    logic        full;
    logic        grant;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic        cdb_jump;
    logic [31:0] cdb_target;
    logic        overflow;
    logic        misbranch;

    int checks;
    int failures;

    alu_cdb #(.ROB_TAG_W(4), .OP_W(6), .DEPTH(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .rdy              (rdy),
        .in_rs_op         (op),
        .in_rs_value1     (v1),
        .in_rs_value2     (v2),
        .in_rs_imm        (imm),
        .in_rs_pc         (pc),
        .in_rs_rob_tag    (tag),
        .out_rs_full      (full),
        .in_cdb_grant     (grant),
        .out_cdb_tag      (cdb_tag),
        .out_cdb_value    (cdb_value),
        .out_cdb_jump     (cdb_jump),
        .out_cdb_target   (cdb_target),
        .out_overflow     (overflow),
        .in_rob_misbranch (misbranch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] i, input logic [31:0] p, input logic [3:0] t);
        op  = o;
        v1  = a;
        v2  = b;
        imm = i;
        pc  = p;
        tag = t;
    endtask

    // Issue one op with grant high; it must be on the bus in the next cycle
    task automatic issue_expect(input string name, input logic [5:0] o,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] i, input logic [31:0] p,
                                input logic [3:0] t, input logic [31:0] e_val,
                                input logic e_jump, input logic [31:0] e_tgt);
        issue(o, a, b, i, p, t);
        grant = 1'b1;
        tick();
        check({name, ".tag"},    {28'd0, cdb_tag},   {28'd0, t});
        check({name, ".value"},  cdb_value,          e_val);
        check({name, ".jump"},   {31'd0, cdb_jump},  {31'd0, e_jump});
        check({name, ".target"}, cdb_target,         e_tgt);
        op = OP_NOP;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b0;
        rdy       = 1'b1;
        grant     = 1'b0;
        misbranch = 1'b0;
        issue(OP_NOP, 0, 0, 0, 0, 0);
        #1;
        check("reset.tag",      {28'd0, cdb_tag},   32'd0);
        check("reset.value",    cdb_value,          32'd0);
        check("reset.jump",     {31'd0, cdb_jump},  32'd0);
        check("reset.target",   cdb_target,         32'd0);
        check("reset.full",     {31'd0, full},      32'd0);
        check("reset.overflow", {31'd0, overflow},  32'd0);
        tick();
        tick();
        rst = 1'b1;

        // Single-op latency and ALU results
        issue_expect("addi", OP_ADDI, 32'hFFFF_FFFF, 0, 32'd1, 0, 4'd3, 32'd0, 1'b0, 32'd0);
        tick();
        check("addi.drain.tag", {28'd0, cdb_tag}, 32'd0);
        issue_expect("blt",   OP_BLT,  32'hFFFF_FFFE, 32'd1, 32'h20, 32'h100, 4'd5, 32'd0, 1'b1, 32'h120);
        issue_expect("bltu",  OP_BLTU, 32'hFFFF_FFFE, 32'd1, 32'h20, 32'h100, 4'd6, 32'd0, 1'b0, 32'h120);
        issue_expect("jalr",  OP_JALR, 32'h1001, 0, 32'd2, 32'h40, 4'd2, 32'h44, 1'b1, 32'h1002);
        issue_expect("sub",   OP_SUB,  32'd5, 32'd7, 0, 0, 4'd8, 32'hFFFF_FFFE, 1'b0, 32'd0);
        issue_expect("slt",   OP_SLT,  32'hFFFF_FFFF, 32'd1, 0, 0, 4'd9, 32'd1, 1'b0, 32'd0);
        issue_expect("sltu",  OP_SLTU, 32'hFFFF_FFFF, 32'd1, 0, 0, 4'd10, 32'd0, 1'b0, 32'd0);
        issue_expect("lui",   OP_LUI,  0, 0, 32'h1234_5000, 0, 4'd11, 32'h1234_5000, 1'b0, 32'd0);
        issue_expect("auipc", OP_AUIPC, 0, 0, 32'hFFFF_F000, 32'h1000, 4'd12, 32'd0, 1'b0, 32'd0);
        issue_expect("jal",   OP_JAL,  0, 0, 32'hFFFF_FF00, 32'h200, 4'd13, 32'h204, 1'b1, 32'h100);
        issue_expect("bge",   OP_BGE,  32'd3, 32'd3, 32'd8, 32'd0, 4'd14, 32'd0, 1'b1, 32'd8);
        issue_expect("srai",  OP_SRAI, 32'h8000_0000, 0, 32'd4, 0, 4'd7, 32'hF800_0000, 1'b0, 32'd0);
        tick();
        check("empty.tag",   {28'd0, cdb_tag},  32'd0);
        check("empty.jump",  {31'd0, cdb_jump}, 32'd0);
        check("empty.hold",  cdb_value,         32'hF800_0000);
        // Tag 0 is never pushed
        issue(OP_ADDI, 1, 0, 1, 0, 4'd0);
        tick();
        check("tag0.nopush", {28'd0, cdb_tag}, 32'd0);

        // Backpressure: fill, overflow, then drain in order
        grant = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            issue(OP_ADDI, 32'd100, 0, 32'(k), 0, 4'(k));
            tick();
            check("bp.full", {31'd0, full}, (k == 3) ? 32'd1 : 32'd0);
        end
        issue(OP_ADDI, 32'd100, 0, 32'd4, 0, 4'd4);
        tick();
        check("bp.fill.head",     {28'd0, cdb_tag},  32'd1);
        check("bp.fill.value",    cdb_value,         32'd101);
        check("bp.fill.overflow", {31'd0, overflow}, 32'd0);
        issue(OP_ADDI, 32'd100, 0, 32'd5, 0, 4'd5);
        tick();
        check("bp.drop.overflow", {31'd0, overflow}, 32'd1);
        check("bp.drop.head",     {28'd0, cdb_tag},  32'd1);
        // Push and pop together while full
        grant = 1'b1;
        issue(OP_ADDI, 32'd100, 0, 32'd8, 0, 4'd8);
        tick();
        check("bp.pp.head",  {28'd0, cdb_tag}, 32'd2);
        check("bp.pp.full",  {31'd0, full},    32'd1);
        check("bp.pp.ovf",   {31'd0, overflow}, 32'd1);
        op = OP_NOP;
        tick();
        check("bp.d3.tag",   {28'd0, cdb_tag}, 32'd3);
        check("bp.d3.full",  {31'd0, full},    32'd1);
        tick();
        check("bp.d4.tag",   {28'd0, cdb_tag}, 32'd4);
        check("bp.d4.value", cdb_value,        32'd104);
        check("bp.d4.full",  {31'd0, full},    32'd0);
        tick();
        check("bp.d8.tag",   {28'd0, cdb_tag}, 32'd8);
        tick();
        check("bp.end.tag",  {28'd0, cdb_tag}, 32'd0);

        // Misbranch with two queued entries and a same-cycle issue
        grant = 1'b0;
        issue(OP_ADDI, 0, 0, 1, 0, 4'd1);
        tick();
        issue(OP_ADDI, 0, 0, 2, 0, 4'd2);
        tick();
        issue(OP_ADDI, 0, 0, 3, 0, 4'd3);
        misbranch = 1'b1;
        grant     = 1'b1;
        tick();
        misbranch = 1'b0;
        check("mis.tag",  {28'd0, cdb_tag},  32'd0);
        check("mis.full", {31'd0, full},     32'd0);
        check("mis.ovf",  {31'd0, overflow}, 32'd1);
        issue(OP_ADDI, 0, 0, 6, 0, 4'd6);
        tick();
        check("mis.next.tag", {28'd0, cdb_tag}, 32'd6);
        op = OP_NOP;
        tick();
        check("mis.next.drain", {28'd0, cdb_tag}, 32'd0);

        // rdy=0 freezes state
        grant = 1'b0;
        issue(OP_ADDI, 0, 0, 4, 0, 4'd4);
        tick();
        rdy   = 1'b0;
        grant = 1'b1;
        issue(OP_ADDI, 0, 0, 5, 0, 4'd5);
        tick();
        check("rdy0.tag", {28'd0, cdb_tag}, 32'd4);
        rdy = 1'b1;
        op  = OP_NOP;
        tick();
        check("rdy1.pop", {28'd0, cdb_tag}, 32'd0);

        // Asynchronous reset in the middle of traffic
        grant = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            issue(OP_ADDI, 0, 0, 32'(k), 0, 4'(k));
            tick();
        end
        op = OP_NOP;
        check("prerst.full", {31'd0, full}, 32'd1);
        rst = 1'b0;
        #1;
        check("arst.tag",  {28'd0, cdb_tag},  32'd0);
        check("arst.full", {31'd0, full},     32'd0);
        check("arst.ovf",  {31'd0, overflow}, 32'd0);
        #2;
        rst   = 1'b1;
        grant = 1'b1;
        tick();
        check("postrst.tag",  {28'd0, cdb_tag}, 32'd0);
        check("postrst.full", {31'd0, full},    32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
